// File: rtl/mem_ops_pkg.sv
// Shared memory-operation encodings for the MEM stage: load funct3 codes,
// store sizes, enable bit positions and the data-memory FSM states.
package mem_ops_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SZ_B  = 2'b00;
   localparam logic [1:0] SZ_H  = 2'b01;
   localparam logic [1:0] SZ_W  = 2'b10;
   localparam logic [1:0] SZ_WX = 2'b11;

   localparam int RD_EN_BIT = 3;
   localparam int WR_EN_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

   // Load funct3 codes that touch fewer than four bytes; everything else is a word.
   function automatic logic isSubWordLoad(input logic [2:0] funct3);
      return (funct3 == F3_LB) || (funct3 == F3_LBU) ||
             (funct3 == F3_LH) || (funct3 == F3_LHU);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and sign/zero extension of a raw 32-bit memory word.
module mem_load_align
   import mem_ops_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_offset, 3'b000} +: 8];
   assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

   always_comb begin
      o_result = i_word;
      case (i_funct3)
         F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_result = {{16{w_half[15]}}, w_half};
         F3_LBU:  o_result = {24'd0, w_byte};
         F3_LHU:  o_result = {16'd0, w_half};
         default: o_result = i_word;
      endcase
   end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory for the MEM stage: latches a request, stalls the
// pipeline for LATENCY+1 cycles, then merges the store or returns the extended load.
module data_mem_unit
   import mem_ops_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mem_read,
   input  logic [2:0]  mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        busywait,
   output logic        misaligned
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mem_state_t         r_state;
   mem_state_t         w_next;
   logic [CNT_W-1:0]   r_count;
   logic               r_rdEn;
   logic [2:0]         r_funct3;
   logic               r_wrEn;
   logic [1:0]         r_size;
   logic [IDX_W+1:0]   r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_mem [DEPTH_WORDS];

   logic               w_request;
   logic               w_load;
   logic               w_commit;
   logic               w_halfAcc;
   logic               w_wordAcc;
   logic               w_misaligned;
   logic [IDX_W-1:0]   w_idx;
   logic [31:0]        w_word;
   logic [3:0]         w_laneMask;
   logic [31:0]        w_laneData;
   logic [31:0]        w_merged;
   logic [31:0]        w_loadResult;
   logic               w_unusedAddrBits;

   // Address bits above the array wrap around and are deliberately dropped.
   assign w_unusedAddrBits = ^address[31:IDX_W+2];

   assign w_request = mem_read[RD_EN_BIT] | mem_write[WR_EN_BIT];

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      busywait = 1'b0;
      w_load   = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busywait = w_request;
            if (w_request) begin
               w_load = 1'b1;
               w_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busywait = 1'b1;
            if (r_count == '0) begin
               w_commit = 1'b1;
               w_next   = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_rdEn   <= 1'b0;
         r_funct3 <= '0;
         r_wrEn   <= 1'b0;
         r_size   <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if (w_load) begin
         r_count  <= CNT_W'(LATENCY - 1);
         r_rdEn   <= mem_read[RD_EN_BIT];
         r_funct3 <= mem_read[2:0];
         r_wrEn   <= mem_write[WR_EN_BIT];
         r_size   <= mem_write[1:0];
         r_addr   <= address[IDX_W+1:0];
         r_wdata  <= write_data;
      end else if (r_state == ST_BUSY && r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   // When both enables are set the store wins, so its size decides alignment.
   assign w_halfAcc    = r_wrEn ? (r_size == SZ_H)
                                : (r_funct3 == F3_LH || r_funct3 == F3_LHU);
   assign w_wordAcc    = r_wrEn ? r_size[1] : !isSubWordLoad(r_funct3);
   assign w_misaligned = (w_halfAcc & r_addr[0]) | (w_wordAcc & (r_addr[1:0] != 2'b00));

   assign w_idx  = r_addr[IDX_W+1:2];
   assign w_word = r_mem[w_idx];

   always_comb begin
      w_laneMask = 4'b1111;
      w_laneData = r_wdata;
      case (r_size)
         SZ_B: begin
            w_laneMask = 4'b0001 << r_addr[1:0];
            w_laneData = {4{r_wdata[7:0]}};
         end
         SZ_H: begin
            w_laneMask = r_addr[1] ? 4'b1100 : 4'b0011;
            w_laneData = {2{r_wdata[15:0]}};
         end
         default: begin
            w_laneMask = 4'b1111;
            w_laneData = r_wdata;
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         w_merged[8*i +: 8] = w_laneMask[i] ? w_laneData[8*i +: 8] : w_word[8*i +: 8];
      end
   end

   // A store still in flight when reset arrives is dropped here.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && r_wrEn && !w_misaligned) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   mem_load_align u_loadAlign (
      .i_word   (w_word),
      .i_offset (r_addr[1:0]),
      .i_funct3 (r_funct3),
      .o_result (w_loadResult)
   );

   // Plain stores leave read_data alone; rejected or mixed accesses return zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data  <= '0;
         misaligned <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         if (w_commit) begin
            misaligned <= w_misaligned;
            if (w_misaligned || (r_wrEn && r_rdEn)) read_data <= '0;
            else if (!r_wrEn)                      read_data <= w_loadResult;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: directed loads/stores push expected
// results, a negedge monitor checks them in the DONE cycle.
module tb_data_mem_unit;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic [3:0]  mem_read;
   logic [2:0]  mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        busywait;
   logic        misaligned;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      string       name;
   } exp_t;

   exp_t expQ[$];
   int   nTests = 0;
   int   nFail  = 0;
   int   busyCnt = 0;
   logic prevBusy = 1'b0;

   data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .busywait   (busywait),
      .misaligned (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: DONE is the first low-busywait cycle after a stall.
   always @(negedge clk) begin
      if (rst) begin
         prevBusy = 1'b0;
         busyCnt  = 0;
      end else begin
         if (busywait) begin
            busyCnt++;
         end else if (prevBusy) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected DONE", 32'(expQ.size()), 32'd1);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput({e.name, " read_data"}, read_data, e.rdata);
               checkOutput({e.name, " misaligned"}, 32'(misaligned), 32'(e.mis));
               checkOutput({e.name, " stall"}, 32'(busyCnt), 32'(LAT + 1));
            end
            busyCnt = 0;
         end
         if (!(prevBusy && !busywait)) begin
            checkOutput("misaligned outside DONE", 32'(misaligned), 32'd0);
         end
         prevBusy = busywait;
      end
   end

   task automatic idleInputs();
      mem_read   = 4'b0000;
      mem_write  = 3'b000;
      address    = 32'd0;
      write_data = 32'd0;
   endtask

   // Called just after a rising edge; returns just after the edge ending DONE.
   task automatic applyStimulus(input string name, input logic [3:0] rd,
                                input logic [2:0] wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRd,
                                input logic expMis);
      bit done = 0;
      exp_t e;
      e.rdata = expRd;
      e.mis   = expMis;
      e.name  = name;
      expQ.push_back(e);
      mem_read   = rd;
      mem_write  = wr;
      address    = addr;
      write_data = wdata;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!busywait) begin
            done = 1;
            break;
         end
      end
      if (!done) checkOutput({name, " timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      idleInputs();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("idle busywait", 32'(busywait), 32'd0);
         checkOutput("idle read_data", read_data, 32'd0);
         checkOutput("idle misaligned", 32'(misaligned), 32'd0);
      end

      applyStimulus("sw 100",       4'b0000, 3'b110, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0);
      applyStimulus("lw 100",       4'b1010, 3'b000, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0);
      applyStimulus("sw 100 b",     4'b0000, 3'b110, 32'h100,  32'h80FF7F01, 32'hDEADBEEF, 1'b0);
      applyStimulus("lb 103",       4'b1000, 3'b000, 32'h103,  32'h0,        32'hFFFFFF80, 1'b0);
      applyStimulus("lbu 103",      4'b1100, 3'b000, 32'h103,  32'h0,        32'h00000080, 1'b0);
      applyStimulus("lh 102",       4'b1001, 3'b000, 32'h102,  32'h0,        32'hFFFF80FF, 1'b0);
      applyStimulus("lhu 100",      4'b1101, 3'b000, 32'h100,  32'h0,        32'h00007F01, 1'b0);
      applyStimulus("lb 101",       4'b1000, 3'b000, 32'h101,  32'h0,        32'h0000007F, 1'b0);
      applyStimulus("lw f3=011",    4'b1011, 3'b000, 32'h100,  32'h0,        32'h80FF7F01, 1'b0);
      applyStimulus("sw 200",       4'b0000, 3'b110, 32'h200,  32'h0,        32'h80FF7F01, 1'b0);
      applyStimulus("sb 201",       4'b0000, 3'b100, 32'h201,  32'h123456AA, 32'h80FF7F01, 1'b0);
      applyStimulus("sh 202",       4'b0000, 3'b101, 32'h202,  32'hFFFF1234, 32'h80FF7F01, 1'b0);
      applyStimulus("lw 200",       4'b1010, 3'b000, 32'h200,  32'h0,        32'h1234AA00, 1'b0);
      applyStimulus("lw 102 mis",   4'b1010, 3'b000, 32'h102,  32'h0,        32'h0,        1'b1);
      applyStimulus("lw 100 chk",   4'b1010, 3'b000, 32'h100,  32'h0,        32'h80FF7F01, 1'b0);
      applyStimulus("sh 101 mis",   4'b0000, 3'b101, 32'h101,  32'h0000FFFF, 32'h0,        1'b1);
      applyStimulus("lw 100 chk2",  4'b1010, 3'b000, 32'h100,  32'h0,        32'h80FF7F01, 1'b0);
      applyStimulus("lh 103 mis",   4'b1001, 3'b000, 32'h103,  32'h0,        32'h0,        1'b1);
      applyStimulus("f3=011 mis",   4'b1011, 3'b000, 32'h101,  32'h0,        32'h0,        1'b1);
      applyStimulus("sw 1000",      4'b0000, 3'b110, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0);
      applyStimulus("lw 0 wrap",    4'b1010, 3'b000, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0);
      applyStimulus("rd+wr 204",    4'b1010, 3'b110, 32'h204,  32'h5A5A5A5A, 32'h0,        1'b0);
      applyStimulus("lw 204",       4'b1010, 3'b000, 32'h204,  32'h0,        32'h5A5A5A5A, 1'b0);
      applyStimulus("sw11 208",     4'b0000, 3'b111, 32'h208,  32'h01020304, 32'h5A5A5A5A, 1'b0);
      applyStimulus("lw 208",       4'b1010, 3'b000, 32'h208,  32'h0,        32'h01020304, 1'b0);
      applyStimulus("lhu 202",      4'b1101, 3'b000, 32'h202,  32'h0,        32'h00001234, 1'b0);
      applyStimulus("lbu 201",      4'b1100, 3'b000, 32'h201,  32'h0,        32'h000000AA, 1'b0);
      applyStimulus("sw 300",       4'b0000, 3'b110, 32'h300,  32'h11223344, 32'h000000AA, 1'b0);
      applyStimulus("lw 300",       4'b1010, 3'b000, 32'h300,  32'h0,        32'h11223344, 1'b0);

      // Abandon a store by resetting in its first BUSY cycle.
      mem_read   = 4'b0000;
      mem_write  = 3'b110;
      address    = 32'h300;
      write_data = 32'h00000055;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idleInputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("post-reset busywait", 32'(busywait), 32'd0);
      checkOutput("post-reset read_data", read_data, 32'd0);
      checkOutput("post-reset misaligned", 32'(misaligned), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("post-reset idle busywait", 32'(busywait), 32'd0);

      applyStimulus("lw 300 after rst", 4'b1010, 3'b000, 32'h300, 32'h0, 32'h11223344, 1'b0);

      for (int n = 0; n < 10 && expQ.size() != 0; n++) @(posedge clk);
      if (expQ.size() != 0) checkOutput("scoreboard drain", 32'(expQ.size()), 32'd0);
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
